// File: rtl/example_down_timer.sv
// Programmable down-counting timer with a one-cycle expiry pulse, a sticky irq and optional auto-reload.
// Optional prescaler enabled with `define EXAMPLE_DOWN_TIMER_PRESCALE_EN (adds the prescale input).
module example_down_timer #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   auto_reload,
  input  logic                   irq_clr,
`ifdef EXAMPLE_DOWN_TIMER_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0] prescale,
`endif
  output logic [WIDTH-1:0]       count,
  output logic                   running,
  output logic                   expired,
  output logic                   irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifndef EXAMPLE_DOWN_TIMER_PRESCALE_EN
  // A fixed prescale of zero keeps the prescale counter at 0, so every RUN cycle is a tick.
  localparam logic [PRESC_WIDTH-1:0] prescale = '0;
`endif

  logic [1:0]             state, state_d;
  logic [WIDTH-1:0]       count_d;
  logic [WIDTH-1:0]       reload_reg, reload_d;
  logic [PRESC_WIDTH-1:0] presc_cnt, presc_d;
  logic                   tick;
  logic                   expire;
  logic                   irq_d;

  assign tick    = (presc_cnt == prescale);
  assign running = (state == ST_RUN);

  // Priority per edge: load > stop > start > decrement (rst is handled in the register block).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state;
    count_d  = count;
    reload_d = reload_reg;
    presc_d  = presc_cnt;
    expire   = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      presc_d  = '0;
      if (load_value == '0)
        state_d = ST_IDLE;
      else if (state == ST_RUN || start)
        state_d = ST_RUN;
      else
        state_d = ST_IDLE;
    end else if (stop) begin
      presc_d = '0;
      if (state == ST_RUN)
        state_d = ST_IDLE;
    end else if (start && state != ST_RUN) begin
      presc_d = '0;
      if (count != '0)
        state_d = ST_RUN;
    end else if (state == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (count == WIDTH'(1)) begin
          expire = 1'b1;
          if (auto_reload && reload_reg != '0) begin
            count_d = reload_reg;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          count_d = count - WIDTH'(1);
        end
      end else begin
        presc_d = presc_cnt + PRESC_WIDTH'(1);
      end
    end
  end

  // A new expiry wins over a simultaneous clear so no event is lost.
  assign irq_d = expire | (irq & ~irq_clr);

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      presc_cnt  <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      reload_reg <= reload_d;
      presc_cnt  <= presc_d;
      expired    <= expire;
      irq        <= irq_d;
    end
  end

endmodule

// File: doc/example_down_timer.md
Name: example_down_timer

Overview:
- Programmable down-counting timer: the count-down counterpart to the free-running up counter in the cocotb example set.
- Loaded with a value, started, and decrements to zero.
- At zero it raises a one-cycle expiry pulse and a sticky interrupt.
- Then either stops or auto-reloads. Used as a cocotb demonstration block exercising an FSM, priorities and a sticky flag ahead of Phase 1 RTL.

Parameters:
WIDTH, 8, bit width of count, load_value and reload register
PRESC_WIDTH, 8, width of prescale input and internal prescale counter (used only with EXAMPLE_DOWN_TIMER_PRESCALE_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  pulse: count and reload_reg <= load_value
load_value  input  WIDTH  value captured on load
start  input  1  pulse: begin counting
stop  input  1  pulse: halt counting, count holds
auto_reload  input  1  level, sampled at expiry edge
irq_clr  input  1  pulse: clear irq
count  output  WIDTH  current count
running  output  1  high while state==RUN
expired  output  1  one-cycle pulse, registered
irq  output  1  sticky expiry flag

Behaviour:
- Reset (rst=1 at edge): state IDLE; count=0, reload_reg=0, running=0, expired=0, irq=0; prescale counter=0. Reset overrides all inputs, including mid-count.
- States: IDLE, RUN, DONE (DONE = expired without reload); running = (state==RUN).
- expired defaults to 0 every cycle; it is 1 only in the cycle after an expiry edge.
- Per-edge priority: rst > load > stop > start > decrement.
- load:
  - count<=load_value, reload_reg<=load_value; no decrement and no expiry that cycle.
  - From DONE -> IDLE. From RUN: stays RUN if load_value!=0, else -> IDLE with no expiry. From IDLE -> IDLE.
  - load+start in the same cycle from IDLE/DONE -> RUN with count=load_value, only if load_value!=0.
- stop: RUN -> IDLE, count holds. No effect in IDLE/DONE. stop+start in the same cycle -> stop wins.
- start:
  - In IDLE/DONE with count!=0 -> RUN.
  - start with count==0 is ignored; state stays IDLE, or DONE stays DONE.
  - start in RUN has no effect.
- Decrement: in RUN, on each tick (every cycle without prescaler), count<=count-1.
- Expiry: in RUN with tick and count==1:
  - expired<=1, irq<=1.
  - If auto_reload==1 and reload_reg!=0: count<=reload_reg, stay RUN. Period = reload_reg ticks.
  - Otherwise: count<=0, -> DONE.
- Consecutive expiries in auto-reload with reload_reg==1: expired stays high every cycle.
- irq: set on expiry, cleared by irq_clr; set wins over simultaneous irq_clr.
- Arithmetic is unsigned, modulo 2^WIDTH. count never underflows, because RUN never holds count==0.

Optional Feature:
- Macro: EXAMPLE_DOWN_TIMER_PRESCALE_EN.
- Defined:
  - Adds input port prescale [PRESC_WIDTH-1:0].
  - Internal prescale counter increments each RUN cycle. Tick occurs when the counter == prescale; the counter then returns to 0.
  - Counter is cleared on rst, load, start and stop.
  - prescale=0 gives a tick every cycle.
  - Decrement happens only on tick, so a count of N lasts N*(prescale+1) cycles.
- Undefined: no prescale port; tick=1 every RUN cycle.

Test Plan:
- Reset, then load_value=5 load, start, auto_reload=0 -> count 5,4,3,2,1,0 on consecutive cycles. expired high exactly 1 cycle, in the cycle count first reads 0. State DONE, running=0, irq=1.
- load 3, auto_reload=1, start, run 10 cycles -> count 3,2,1,3,2,1,3,... expired pulses every 3 cycles; running stays 1.
- load 8, start, stop after 3 decrements -> count holds 5, running=0. start -> resumes 4,3,...
- Simultaneous: stop+start in RUN -> IDLE. load_value=9 load during RUN at count 2 -> count 9, no expired. irq_clr in the same cycle as expiry -> irq=1.
- start with count==0 after reset -> stays IDLE, running=0. load 0 during RUN -> IDLE, expired=0. rst asserted mid-count -> all outputs 0 next cycle.
- With EXAMPLE_DOWN_TIMER_PRESCALE_EN, prescale=2, load 2, start -> count decrements every 3 cycles. expired at cycle 6 after start.
